// File: rtl/dsp_fmt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dsp_fmt_pkg
// Description : Shared widths, FIFO entry type and saturation helper for the
//               accumulator result formatter.
// Revision    : 1.0 - initial release
// ============================================================================
package dsp_fmt_pkg;

    localparam int P_W     = 64;
    localparam int SHIFT_W = 6;

    // Widest supported entry; the top level slices data down to OUT_W bits.
    typedef struct packed {
        logic        sat;
        logic [31:0] data;
    } fmt_word_t;

    function automatic fmt_word_t sat_to_w(input logic signed [P_W:0] value, input int width);
        logic signed [P_W:0] max_v;
        logic signed [P_W:0] min_v;
        fmt_word_t           res;
        max_v = (65'sd1 << (width - 1)) - 65'sd1;
        min_v = -(65'sd1 << (width - 1));
        res.sat  = 1'b0;
        res.data = value[31:0];
        if (value > max_v) begin
            res.sat  = 1'b1;
            res.data = max_v[31:0];
        end else if (value < min_v) begin
            res.sat  = 1'b1;
            res.data = min_v[31:0];
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dsp_result_fifo.sv
`default_nettype none
// ============================================================================
// Module      : dsp_result_fifo
// Description : Synchronous first-word-fall-through FIFO, pointer-plus-count.
// Revision    : 1.0 - initial release
// ============================================================================
module dsp_result_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] dout
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign empty     = (r_count == '0);
    assign full      = (r_count == (c_PTR_W + 1)'(DEPTH));
    assign w_do_pop  = pop && !empty;
    // A pop frees the slot being written, so a full FIFO still accepts a push.
    assign w_do_push = push && (!full || w_do_pop);
    assign dout      = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= din;
                r_wr_ptr        <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (c_PTR_W + 1)'(1);
                2'b01:   r_count <= r_count - (c_PTR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/accum_result_formatter.sv
`default_nettype none
// ============================================================================
// Module      : accum_result_formatter
// Description : Rounds, shifts and saturates 64-bit MAC results into a FIFO
//               streamed out on valid/ready, with saturation/drop statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module accum_result_formatter
    import dsp_fmt_pkg::*;
#(
    parameter int OUT_W      = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [P_W-1:0]     p_i,
    input  logic               p_valid_i,
    input  logic [SHIFT_W-1:0] shift_i,
    input  logic               round_en_i,
    input  logic               clear_stats_i,
    output logic [OUT_W-1:0]   data_o,
    output logic               sat_o,
    output logic               valid_o,
    input  logic               ready_i,
    output logic               overflow_o,
    output logic [CNT_W-1:0]   sat_cnt_o,
    output logic [CNT_W-1:0]   drop_cnt_o
);

    localparam int         c_ENTRY_W = OUT_W + 1;
    localparam logic [P_W:0] c_ONE   = (P_W + 1)'(1);
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    logic signed [P_W:0]  w_round;
    logic signed [P_W:0]  w_sum;
    logic signed [P_W:0]  w_shifted;
    logic                 r_s1_valid;
    logic signed [P_W:0]  r_s1_v;
    fmt_word_t            w_fmt;
    logic [c_ENTRY_W-1:0] w_entry;
    logic [c_ENTRY_W-1:0] w_head;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_drop;
    logic [CNT_W-1:0]     r_sat_cnt;
    logic [CNT_W-1:0]     r_drop_cnt;
    logic                 r_overflow;

    // 65-bit sum keeps the half-up rounding add from wrapping at the extremes.
    always_comb begin
        w_round = '0;
        if (round_en_i && (shift_i != '0)) begin
            w_round = c_ONE << (shift_i - SHIFT_W'(1));
        end
        w_sum     = $signed({p_i[P_W-1], p_i}) + w_round;
        w_shifted = w_sum >>> shift_i;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_v     <= '0;
        end else begin
            r_s1_valid <= p_valid_i;
            if (p_valid_i) begin
                r_s1_v <= w_shifted;
            end
        end
    end

    assign w_fmt   = sat_to_w(r_s1_v, OUT_W);
    assign w_entry = {w_fmt.sat, w_fmt.data[OUT_W-1:0]};

    if (OUT_W < 32) begin : g_unused_hi
        logic w_unused_hi;
        assign w_unused_hi = ^w_fmt.data[31:OUT_W];
    end

    assign w_pop  = !w_empty && ready_i;
    assign w_push = r_s1_valid && (!w_full || w_pop);
    assign w_drop = r_s1_valid && w_full && !w_pop;

    dsp_result_fifo #(
        .WIDTH (c_ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_entry),
        .full  (w_full),
        .empty (w_empty),
        .dout  (w_head)
    );

    always_ff @(posedge clk) begin
        if (reset || clear_stats_i) begin
            r_sat_cnt  <= '0;
            r_drop_cnt <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push && w_fmt.sat && (r_sat_cnt != c_CNT_MAX)) begin
                r_sat_cnt <= r_sat_cnt + CNT_W'(1);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != c_CNT_MAX) begin
                    r_drop_cnt <= r_drop_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign valid_o    = !w_empty;
    assign data_o     = w_head[OUT_W-1:0];
    assign sat_o      = w_head[OUT_W];
    assign overflow_o = r_overflow;
    assign sat_cnt_o  = r_sat_cnt;
    assign drop_cnt_o = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_accum_result_formatter.sv
`default_nettype none
// ============================================================================
// Module      : tb_accum_result_formatter
// Description : Scoreboard bench for accum_result_formatter (OUT_W=16, depth 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_accum_result_formatter;

    logic        clk;
    logic        rst;
    logic [63:0] p_i;
    logic        p_valid_i;
    logic [5:0]  shift_i;
    logic        round_en_i;
    logic        clear_stats_i;
    logic [15:0] data_o;
    logic        sat_o;
    logic        valid_o;
    logic        ready_i;
    logic        overflow_o;
    logic [15:0] sat_cnt_o;
    logic [15:0] drop_cnt_o;

    int n_vec;
    int n_err;
    logic [16:0] exp_q [$];

    accum_result_formatter #(
        .OUT_W      (16),
        .FIFO_DEPTH (4),
        .CNT_W      (16)
    ) dut (
        .clk           (clk),
        .reset         (rst),
        .p_i           (p_i),
        .p_valid_i     (p_valid_i),
        .shift_i       (shift_i),
        .round_en_i    (round_en_i),
        .clear_stats_i (clear_stats_i),
        .data_o        (data_o),
        .sat_o         (sat_o),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .overflow_o    (overflow_o),
        .sat_cnt_o     (sat_cnt_o),
        .drop_cnt_o    (drop_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted output word is compared against the scoreboard head.
    always @(negedge clk) begin
        if (!rst && valid_o && ready_i) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_word: got sat=%0b data=0x%0h, expected none", sat_o, data_o);
            end else begin
                logic [16:0] e;
                e = exp_q.pop_front();
                if ({sat_o, data_o} !== e) begin
                    n_err++;
                    $display("FAIL out_word: got sat=%0b data=0x%0h, expected sat=%0b data=0x%0h",
                             sat_o, data_o, e[16], e[15:0]);
                end
            end
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One-cycle p_valid pulse; expected word is queued only if it will be kept.
    task automatic send(input logic [63:0] p, input logic [5:0] sh, input logic rnd,
                        input logic [15:0] e_data, input logic e_sat, input logic keep);
        p_i        = p;
        shift_i    = sh;
        round_en_i = rnd;
        p_valid_i  = 1'b1;
        if (keep) exp_q.push_back({e_sat, e_data});
        tick(1);
        p_valid_i  = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int cyc;
        cyc = 0;
        while ((exp_q.size() != 0) && (cyc < 50)) begin
            tick(1);
            cyc++;
        end
        check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1; p_i = '0; p_valid_i = 1'b0; shift_i = '0; round_en_i = 1'b0;
        clear_stats_i = 1'b0; ready_i = 1'b0;

        // 1. reset
        tick(2);
        check("rst_data", 64'(data_o), 64'd0);
        check("rst_valid", 64'(valid_o), 64'd0);
        check("rst_overflow", 64'(overflow_o), 64'd0);
        check("rst_sat_cnt", 64'(sat_cnt_o), 64'd0);
        check("rst_drop_cnt", 64'(drop_cnt_o), 64'd0);
        rst = 1'b0;
        ready_i = 1'b1;
        tick(1);

        // 2. basic shift and latency
        send(64'h12345, 6'd4, 1'b0, 16'h1234, 1'b0, 1'b1);
        check("lat_n1_valid", 64'(valid_o), 64'd0);
        tick(1);
        check("lat_n2_valid", 64'(valid_o), 64'd1);
        wait_drain("basic");

        // 3. rounding
        send(64'd24, 6'd4, 1'b1, 16'd2, 1'b0, 1'b1);
        send(64'd24, 6'd4, 1'b0, 16'd1, 1'b0, 1'b1);
        send(-64'sd24, 6'd4, 1'b1, 16'hFFFF, 1'b0, 1'b1);
        send(-64'sd24, 6'd4, 1'b0, 16'hFFFE, 1'b0, 1'b1);
        wait_drain("round");

        // 4. saturation and stats clear
        send(64'h100_0000_0000, 6'd0, 1'b0, 16'h7FFF, 1'b1, 1'b1);
        send(-64'sh100_0000_0000, 6'd0, 1'b0, 16'h8000, 1'b1, 1'b1);
        wait_drain("sat");
        tick(1);
        check("sat_cnt_2", 64'(sat_cnt_o), 64'd2);
        clear_stats_i = 1'b1;
        tick(1);
        clear_stats_i = 1'b0;
        check("sat_cnt_clr", 64'(sat_cnt_o), 64'd0);

        // 5. backpressure: 1..4 kept, 5 and 6 dropped
        ready_i = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            send(64'(i), 6'd0, 1'b0, 16'(i), 1'b0, (i <= 4));
        end
        tick(3);
        check("bp_valid", 64'(valid_o), 64'd1);
        check("bp_head", 64'(data_o), 64'd1);
        check("bp_drop_cnt", 64'(drop_cnt_o), 64'd2);
        check("bp_overflow", 64'(overflow_o), 64'd1);
        tick(2);
        check("bp_head_stable", 64'(data_o), 64'd1);
        ready_i = 1'b1;
        tick(3);
        check("bp_valid_after3", 64'(valid_o), 64'd1);
        tick(1);
        check("bp_valid_after4", 64'(valid_o), 64'd0);
        check("bp_q_empty", 64'(exp_q.size()), 64'd0);

        // 6. full FIFO plus continuous stream with ready, then reset mid-drain
        clear_stats_i = 1'b1;
        tick(1);
        clear_stats_i = 1'b0;
        check("clr_drop_cnt", 64'(drop_cnt_o), 64'd0);
        check("clr_overflow", 64'(overflow_o), 64'd0);
        ready_i = 1'b0;
        for (int i = 10; i <= 13; i++) send(64'(i), 6'd0, 1'b0, 16'(i), 1'b0, 1'b1);
        tick(2);
        ready_i = 1'b1;
        for (int i = 20; i <= 27; i++) send(64'(i), 6'd0, 1'b0, 16'(i), 1'b0, 1'b1);
        tick(1);
        check("stream_drop_cnt", 64'(drop_cnt_o), 64'd0);
        check("stream_overflow", 64'(overflow_o), 64'd0);
        rst = 1'b1;
        tick(1);
        exp_q.delete();
        check("midrst_valid", 64'(valid_o), 64'd0);
        check("midrst_sat_cnt", 64'(sat_cnt_o), 64'd0);
        check("midrst_drop_cnt", 64'(drop_cnt_o), 64'd0);
        check("midrst_overflow", 64'(overflow_o), 64'd0);
        rst = 1'b0;
        tick(3);
        check("postrst_valid", 64'(valid_o), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
